// File: rtl/keypad_pkg.sv
// Shared types and keymap for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned CODE_W  = 4;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } acc_state_e;

    typedef struct packed {
        res_kind_e         kind;
        logic [CODE_W-1:0] code;
    } scan_res_t;

    localparam logic [CODE_W-1:0] KEYMAP [KP_ROWS][KP_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // Pressed-key matrix (bit r*4+c) to scan result; code is zero unless SINGLE.
    function automatic scan_res_t classify(input logic [KP_ROWS*KP_COLS-1:0] m);
        scan_res_t  res;
        logic [4:0] n;
        n        = '0;
        res.code = '0;
        for (int r = 0; r < KP_ROWS; r++) begin
            for (int c = 0; c < KP_COLS; c++) begin
                if (m[4'(r*KP_COLS + c)]) begin
                    n        = n + 5'd1;
                    res.code = KEYMAP[2'(r)][2'(c)];
                end
            end
        end
        if (n == 5'd0) begin
            res.kind = RES_NONE;
        end else if (n == 5'd1) begin
            res.kind = RES_SINGLE;
        end else begin
            res.kind = RES_MULTI;
        end
        if (res.kind != RES_SINGLE) begin
            res.code = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-result debouncer and key accept FSM; produces the registered key outputs.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_scan_done,
    input  scan_res_t         i_res,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    scan_res_t         r_prev;
    logic [CNT_W-1:0]  r_cnt;
    acc_state_e        r_state;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_held;

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_stable;
    acc_state_e        w_state_next;
    logic [CODE_W-1:0] w_code_next;
    logic              w_valid_next;
    logic              w_held_next;

    // Run length of identical scan results, saturating at the threshold.
    always_comb begin
        w_cnt_next = CNT_W'(1);
        if (i_res == r_prev) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
        w_stable = (w_cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '{kind: RES_NONE, code: '0};
            r_cnt  <= '0;
        end else if (i_scan_done) begin
            r_prev <= i_res;
            r_cnt  <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
            r_key_held  <= w_held_next;
        end
    end

    // In HELD, r_key_code is the accepted key, so a different SINGLE is a roll-over.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_key_code;
        w_valid_next = 1'b0;
        w_held_next  = r_key_held;
        if (i_scan_done && w_stable) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_res.kind == RES_SINGLE) begin
                        w_state_next = ST_HELD;
                        w_code_next  = i_res.code;
                        w_valid_next = 1'b1;
                        w_held_next  = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (i_res.kind == RES_SINGLE && i_res.code != r_key_code) begin
                        w_code_next  = i_res.code;
                        w_valid_next = 1'b1;
                    end else if (i_res.kind == RES_NONE) begin
                        w_state_next = ST_IDLE;
                        w_held_next  = 1'b0;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row sampling and debounced key output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KP_ROWS-1:0]    row_n,
    output logic [KP_COLS-1:0]    col_n,
    output logic [CODE_W-1:0]     key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [KP_ROWS-1:0]            r_row_s1;
    logic [KP_ROWS-1:0]            r_row_s2;
    logic [DWELL_W-1:0]            r_dwell;
    logic [1:0]                    r_col;
    logic [KP_COLS-1:0]            r_col_n;
    logic [2:0][KP_ROWS-1:0]       r_samp;

    logic                          w_last_dwell;
    logic                          w_scan_done;
    logic [1:0]                    w_col_next;
    logic [KP_ROWS-1:0]            w_pressed;
    logic [KP_ROWS*KP_COLS-1:0]    w_matrix;
    scan_res_t                     w_res;

    assign w_last_dwell = (r_dwell == DWELL_LAST);
    assign w_scan_done  = w_last_dwell && (r_col == 2'd3);
    assign w_col_next   = r_col + 2'd1;
    assign w_pressed    = ~r_row_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    // Column 3 is not stored: its sample goes straight into the scan result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_col   <= '0;
            r_col_n <= 4'b1110;
            r_samp  <= '0;
        end else if (w_last_dwell) begin
            r_dwell <= '0;
            r_col   <= w_col_next;
            r_col_n <= ~(4'b0001 << w_col_next);
            case (r_col)
                2'd0:    r_samp[0] <= w_pressed;
                2'd1:    r_samp[1] <= w_pressed;
                2'd2:    r_samp[2] <= w_pressed;
                default: ;
            endcase
        end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
        end
    end

    always_comb begin
        w_matrix = '0;
        for (int r = 0; r < KP_ROWS; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_matrix[4'(r*KP_COLS + c)] = r_samp[2'(c)][2'(r)];
            end
            w_matrix[4'(r*KP_COLS + 3)] = w_pressed[2'(r)];
        end
        w_res = classify(w_matrix);
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_scan_done (w_scan_done),
        .i_res       (w_res),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held)
    );

    assign col_n = r_col_n;

endmodule
